// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one memory port between fetch (I)
//               and load/store (D); one transaction in flight, with watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_rd_i,
    input  logic [31:0] i_addr_i,
    output logic        i_ready_o,
    output logic [31:0] i_data_o,
    output logic        i_err_o,
    input  logic        d_rd_i,
    input  logic        d_wr_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_data_i,
    input  logic [3:0]  d_byte_select_i,
    output logic        d_ready_o,
    output logic [31:0] d_data_o,
    output logic        d_err_o,
    input  logic        merged_mem_ready_i,
    input  logic [31:0] merged_mem_data_i,
    output logic        merged_mem_rd_o,
    output logic        merged_mem_wr_o,
    output logic [31:0] merged_mem_addr_o,
    output logic [31:0] merged_mem_data_o,
    output logic [3:0]  byte_select_o
);

    localparam logic [1:0]       c_S_IDLE    = 2'd0;
    localparam logic [1:0]       c_S_GRANT_I = 2'd1;
    localparam logic [1:0]       c_S_GRANT_D = 2'd2;
    localparam logic             c_OWNER_I   = 1'b0;
    localparam logic             c_OWNER_D   = 1'b1;
    localparam logic             c_WD_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] c_WD_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state,      w_state_nxt;
    logic             r_last_grant, w_last_grant_nxt;
    logic             r_mem_rd,     w_mem_rd_nxt;
    logic             r_mem_wr,     w_mem_wr_nxt;
    logic [31:0]      r_mem_addr,   w_mem_addr_nxt;
    logic [31:0]      r_mem_data,   w_mem_data_nxt;
    logic [3:0]       r_byte_sel,   w_byte_sel_nxt;
    logic [CNT_W-1:0] r_wd_cnt,     w_wd_cnt_nxt;

    logic w_i_req;
    logic w_d_req;
    logic w_granted;
    logic w_timeout;
    logic w_done;

    assign w_i_req   = i_rd_i;
    assign w_d_req   = d_rd_i | d_wr_i;
    assign w_granted = (r_state != c_S_IDLE);
    // A ready arriving on the last watchdog cycle wins over the timeout.
    assign w_timeout = c_WD_EN & w_granted & ~merged_mem_ready_i & (r_wd_cnt == c_WD_LAST);
    assign w_done    = w_granted & (merged_mem_ready_i | w_timeout);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= c_S_IDLE;
            r_last_grant <= c_OWNER_D;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_byte_sel   <= '0;
            r_wd_cnt     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_mem_rd     <= w_mem_rd_nxt;
            r_mem_wr     <= w_mem_wr_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_data   <= w_mem_data_nxt;
            r_byte_sel   <= w_byte_sel_nxt;
            r_wd_cnt     <= w_wd_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_mem_rd_nxt     = r_mem_rd;
        w_mem_wr_nxt     = r_mem_wr;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_data_nxt   = r_mem_data;
        w_byte_sel_nxt   = r_byte_sel;
        w_wd_cnt_nxt     = r_wd_cnt;
        case (r_state)
            c_S_IDLE: begin
                if (w_i_req && (!w_d_req || (r_last_grant == c_OWNER_D))) begin
                    w_state_nxt      = c_S_GRANT_I;
                    w_last_grant_nxt = c_OWNER_I;
                    w_mem_rd_nxt     = 1'b1;
                    w_mem_wr_nxt     = 1'b0;
                    w_mem_addr_nxt   = i_addr_i;
                    w_mem_data_nxt   = '0;
                    w_byte_sel_nxt   = 4'b1111;
                    w_wd_cnt_nxt     = '0;
                end else if (w_d_req) begin
                    w_state_nxt      = c_S_GRANT_D;
                    w_last_grant_nxt = c_OWNER_D;
                    w_mem_rd_nxt     = d_rd_i & ~d_wr_i;
                    w_mem_wr_nxt     = d_wr_i;
                    w_mem_addr_nxt   = d_addr_i;
                    w_mem_data_nxt   = d_data_i;
                    w_byte_sel_nxt   = d_byte_select_i;
                    w_wd_cnt_nxt     = '0;
                end
            end
            c_S_GRANT_I, c_S_GRANT_D: begin
                if (w_done) begin
                    w_state_nxt  = c_S_IDLE;
                    w_mem_rd_nxt = 1'b0;
                    w_mem_wr_nxt = 1'b0;
                end else if (c_WD_EN) begin
                    w_wd_cnt_nxt = r_wd_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt  = c_S_IDLE;
                w_mem_rd_nxt = 1'b0;
                w_mem_wr_nxt = 1'b0;
            end
        endcase
    end

    assign i_ready_o = w_done & (r_state == c_S_GRANT_I);
    assign i_err_o   = w_timeout & (r_state == c_S_GRANT_I);
    assign i_data_o  = ((r_state == c_S_GRANT_I) && merged_mem_ready_i) ? merged_mem_data_i : '0;
    assign d_ready_o = w_done & (r_state == c_S_GRANT_D);
    assign d_err_o   = w_timeout & (r_state == c_S_GRANT_D);
    assign d_data_o  = ((r_state == c_S_GRANT_D) && merged_mem_ready_i) ? merged_mem_data_i : '0;

    assign merged_mem_rd_o   = r_mem_rd;
    assign merged_mem_wr_o   = r_mem_wr;
    assign merged_mem_addr_o = r_mem_addr;
    assign merged_mem_data_o = r_mem_data;
    assign byte_select_o     = r_byte_sel;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single merged memory port (ready/rd/wr/addr/data/byte_select) between two requesters: instruction fetch (port I) and load/store (port D).
- Sits between the CPU core's fetch and load/store units and the RAM wrapper.
- Round-robin grant, one transaction in flight, latched request, optional watchdog timeout.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles a granted transaction may wait for memory ready before being aborted; 0 disables the watchdog.
- CNT_W, 11, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- i_rd_i  in  1  instruction read request, level, held until i_ready_o
- i_addr_i  in  32  instruction byte address
- i_ready_o  out  1  one-cycle completion pulse to port I
- i_data_o  out  32  read data to port I, valid while i_ready_o
- i_err_o  out  1  timeout flag, valid with i_ready_o
- d_rd_i  in  1  data read request, level, held until d_ready_o
- d_wr_i  in  1  data write request, level, held until d_ready_o
- d_addr_i  in  32  data byte address
- d_data_i  in  32  write data
- d_byte_select_i  in  4  byte lanes
- d_ready_o  out  1  one-cycle completion pulse to port D
- d_data_o  out  32  read data to port D, valid while d_ready_o
- d_err_o  out  1  timeout flag, valid with d_ready_o
- merged_mem_ready_i  in  1  memory completion pulse
- merged_mem_data_i  in  32  memory read data
- merged_mem_rd_o  out  1  memory read strobe (registered)
- merged_mem_wr_o  out  1  memory write strobe (registered)
- merged_mem_addr_o  out  32  memory address (registered)
- merged_mem_data_o  out  32  memory write data (registered)
- byte_select_o  out  4  memory byte lanes (registered)

Behaviour:
- FSM states: IDLE, GRANT_I, GRANT_D. Registers: state, last_grant (0=I, 1=D), latched rd/wr/addr/data/byte_select, wd_cnt.
- Reset (async, rst_i=1): state=IDLE, last_grant=D, all merged_mem_* outputs and byte_select_o = 0, wd_cnt=0, both ready and err outputs 0, both data outputs 0.
- IDLE, single requester active: grant it at the next edge. Port I is active when i_rd_i=1; port D when d_rd_i or d_wr_i=1.
- IDLE, both active: grant the port that is not last_grant. last_grant is updated on grant.
- On grant: latch the owner's request into the merged_mem_* registers. Port I: rd=1, wr=0, byte_select=4'b1111, data=0. Port D with d_wr_i=1: wr=1, rd=0, regardless of d_rd_i.
- Request-to-strobe latency: request seen in IDLE at cycle N; strobe visible from cycle N+1.
- While granted: outputs stay constant. Requester input changes are ignored until completion.
- Completion: merged_mem_ready_i=1 while granted →
  - same cycle (combinational): owner ready_o=1, owner data_o=merged_mem_data_i, err_o=0;
  - next edge: state=IDLE, rd/wr cleared.
  - The non-owner's ready_o is always 0.
  - merged_mem_ready_i in IDLE is ignored.
- Minimum one IDLE cycle between transactions; peak throughput is one transfer per (memory latency + 1) cycles.
- Watchdog (TIMEOUT_CYCLES>0):
  - wd_cnt clears on grant and increments each granted cycle without ready.
  - When wd_cnt == TIMEOUT_CYCLES-1 and no ready: owner ready_o=1, err_o=1, data_o=0 that cycle; state=IDLE and strobes cleared at the next edge.
  - Ready arriving in that same cycle takes precedence: normal completion, err_o=0.
- data_o of a port is 0 whenever its ready_o is 0.
- Reset asserted mid-transaction: strobes drop immediately, no ready is issued, and the pending request is lost. Requesters re-issue after reset.

Test Plan:
- Only I reads 0x100; RAM returns 0xDEADBEEF after 2 cycles → merged_mem_rd_o high from cycle 1, addr=0x100, byte_select=1111; i_ready_o pulses 1 cycle with i_data_o=0xDEADBEEF; i_err_o=0.
- I and D (write 0x12345678 to 0x200, lanes 0011) assert together after reset → I granted first. D is granted on the IDLE cycle after I completes, with wr=1, data=0x12345678, byte_select=0011. Repeating both requests continuously alternates grants I,D,I,D.
- D asserts d_rd_i and d_wr_i together → only merged_mem_wr_o=1; d_ready_o on completion.
- Memory never answers, TIMEOUT_CYCLES=8 → owner ready_o and err_o high together on the 8th granted cycle, data_o=0; strobes low the next cycle and the arbiter then grants the other pending requester.
- rst_i pulsed while GRANT_D waits → merged_mem_wr_o/rd_o drop without waiting for a clock edge; no d_ready_o; after release the first simultaneous request goes to I.
- merged_mem_ready_i pulsed in IDLE → no ready_o on either port and no state change.
